imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage. It supersedes the purely combinational immediate extender and adds:
- XLEN-generic sign extension (32 or 64).
- Shift-amount and CSR-zimm formats.
- A valid/ready handshake with a 2-entry skid buffer, so the decode→execute boundary can absorb a one-cycle backpressure without a combinational ready path.
- A pass-through tag (PC) that stays aligned with its immediate.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 32, width of sideband tag carried alongside each immediate (PC).

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  reset, asynchronous assert, active-low.
i_flush  in  1  synchronous flush; drops all buffered entries.
i_valid  in  1  upstream has an instruction.
o_ready  out  1  block can accept; registered, no combinational path from i_ready.
i_instr  in  25  instruction bits [31:7].
i_immsrc  in  3  format select (imm_src_e).
i_tag  in  TAG_W  sideband tag.
o_valid  out  1  output entry valid.
i_ready  in  1  downstream accepts.
o_immext  out  XLEN  extended immediate.
o_tag  out  TAG_W  tag of the output entry.
o_immsrc_err  out  1  output entry used an undefined format code.

Behaviour:
- Reset (i_rst_n=0, async):
  - o_valid=0, o_ready=1.
  - o_immext=0, o_tag=0, o_immsrc_err=0.
  - Both buffer slots are empty.
- Handshakes:
  - Accept = i_valid & o_ready.
  - Emit = o_valid & i_ready.
- Formats, with S = sign bit instr[31] replicated to XLEN:
  - 000 I: S & instr[31:20].
  - 001 S: S & instr[31:25], instr[11:7].
  - 010 B: S & instr[7], instr[30:25], instr[11:8], 0.
  - 011 J: S & instr[19:12], instr[20], instr[30:21], 0.
  - 100 U: instr[31:12], 12'b0, sign-extended to XLEN (RV64 LUI semantics).
  - 101 SHAMT: zero-extended instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
  - 110 ZIMM: zero-extended instr[19:15].
  - 111 undefined: immediate 0, err=1.
- The extension is computed combinationally at accept and stored. Stored fields per entry: immediate, tag, err.
- Latency: 1 cycle. An entry accepted at edge N appears on outputs after edge N (o_valid=1 in cycle N+1).
- Storage is a main output register plus one skid register:
  - Output register empty, or emit in the same cycle → accepted data goes to the output register.
  - Output register full and no emit → accepted data goes to the skid register, and o_ready deasserts at the next edge.
  - Emit while skid full → skid moves to the output register; o_ready reasserts at the next edge.
  - Accept and emit in the same cycle with skid empty → output register is replaced, no bubble; sustains 1 entry/cycle.
- o_ready = ~skid_full (registered). Ordering is strictly FIFO; no entry is dropped or duplicated.
- Output stability: while o_valid=1 and i_ready=0, o_immext, o_tag and o_immsrc_err hold stable.
- i_flush = 1:
  - At the next edge, both slots empty: o_valid=0, o_ready=1.
  - Any same-cycle accept is discarded. Flush has priority over accept and emit.
- Reset mid-transfer: buffered entries are lost immediately (async); outputs go to reset values without waiting for a clock.
- Outputs stay at their last value when o_valid=0. Only o_valid is qualifying.
- XLEN not in {32,64} is an elaboration error.

Decomposition:
- Shared package pbl3_pkg:
  - typedef enum logic [2:0] imm_src_e (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT, IMM_ZIMM, IMM_NONE).
  - Localparam XLEN_DEFAULT=32.
- Sub-module imm_gen_comb #(XLEN): purely combinational format decode (instr, immsrc → imm, err). It is reused by the execute-stage forwarding checks.
- imm_gen_pipe holds only the skid/handshake logic.

Test Plan:
1. Single transfer per format, XLEN=32, i_ready=1, each with o_valid exactly 1 cycle after accept:
   - I: instr 0xFFF00093 (addi x1,x0,-1), immsrc 000 → o_immext 0xFFFFFFFF.
   - B: instr 0xFE000EE3 (beq x0,x0,-4), immsrc 010 → 0xFFFFFFFC.
   - U: 0x123452B7 (lui x5,0x12345), immsrc 100 → 0x12345000.
   - SHAMT: 0x01F09093, immsrc 101 → 0x0000001F.
   - ZIMM: csrrwi with rs1=11111, immsrc 110 → 0x0000001F.
   - Undefined: immsrc 111 → immext 0, err=1.
2. XLEN=64:
   - I: instr 0xFFF00093, immsrc 000 → 0xFFFFFFFFFFFFFFFF.
   - U: 0x800002B7, immsrc 100 → 0xFFFFFFFF80000000.
   - SHAMT: slli with shamt=63, immsrc 101 → 0x3F.
3. Backpressure:
   - Stimulus: hold i_ready=0, present i_valid=1 with tags A, B, C on consecutive cycles.
   - Required while stalled: A and B accepted; o_ready=0 from the cycle after B; C held; o_immext/o_tag stable on A.
   - Required on release of i_ready: tags emerge A, B, C in order with no gaps.
4. Streaming: i_valid=i_ready=1 for 16 cycles with tags 0..15 → 16 outputs on consecutive cycles, o_ready never drops.
5. Flush with both slots full and i_valid=1 → next cycle o_valid=0, o_ready=1; the flushed entries and the same-cycle input never appear.
6. Async reset: assert i_rst_n=0 between clock edges with both slots full → o_valid=0 and o_ready=1 immediately. After release, the first accepted instruction emerges alone after 1 cycle.

Source files
------------

// File: rtl/pbl3_pkg.sv
// Shared decode-stage definitions: immediate format codes and default datapath width.
package pbl3_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_J     = 3'd3,
    IMM_U     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_ZIMM  = 3'd6,
    IMM_NONE  = 3'd7
  } imm_src_e;

  localparam int XLEN_DEFAULT = 32;

endpackage

// File: rtl/imm_gen_comb.sv
// Purely combinational immediate decode: instruction bits [31:7] and format code to
// an XLEN-wide immediate plus an undefined-format flag.
module imm_gen_comb
  import pbl3_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [24:0]     instr,
  input  imm_src_e        immsrc,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Re-index so the slices below read like the ISA manual's bit numbers.
  logic [31:7] ins;
  assign ins = instr;

  always_comb begin
    imm = {XLEN{ins[31]}};
    err = 1'b0;
    case (immsrc)
      IMM_I: imm[11:0] = ins[31:20];
      IMM_S: imm[11:0] = {ins[31:25], ins[11:7]};
      IMM_B: imm[12:0] = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J: imm[20:0] = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_U: imm[31:0] = {ins[31:12], 12'b0};
      IMM_SHAMT: begin
        imm = '0;
        if (XLEN == 64) imm[5:0] = ins[25:20];
        else            imm[4:0] = ins[24:20];
      end
      IMM_ZIMM: begin
        imm      = '0;
        imm[4:0] = ins[19:15];
      end
      default: begin
        imm = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a valid/ready handshake backed by an output
// register plus one skid register; the tag travels with its immediate.
module imm_gen_pipe
  import pbl3_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [24:0]      i_instr,
  input  logic [2:0]       i_immsrc,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_immext,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_immsrc_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  new_imm;
  logic             new_err;

  imm_gen_comb #(.XLEN(XLEN)) u_comb (
    .instr  (i_instr),
    .immsrc (imm_src_e'(i_immsrc)),
    .imm    (new_imm),
    .err    (new_err)
  );

  logic             out_valid_reg;
  logic [XLEN-1:0]  out_imm_reg;
  logic [TAG_W-1:0] out_tag_reg;
  logic             out_err_reg;
  logic             skid_valid_reg;
  logic [XLEN-1:0]  skid_imm_reg;
  logic [TAG_W-1:0] skid_tag_reg;
  logic             skid_err_reg;

  logic accept;
  logic emit;

  // Ready depends only on skid occupancy, so there is no path from i_ready.
  assign o_ready      = ~skid_valid_reg;
  assign o_valid      = out_valid_reg;
  assign o_immext     = out_imm_reg;
  assign o_tag        = out_tag_reg;
  assign o_immsrc_err = out_err_reg;

  assign accept = i_valid & o_ready;
  assign emit   = out_valid_reg & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_reg  <= 1'b0;
      out_imm_reg    <= '0;
      out_tag_reg    <= '0;
      out_err_reg    <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_imm_reg   <= '0;
      skid_tag_reg   <= '0;
      skid_err_reg   <= 1'b0;
    end else if (i_flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (emit) begin
      // With the skid full, o_ready is low, so no accept can coincide here.
      if (skid_valid_reg) begin
        out_imm_reg    <= skid_imm_reg;
        out_tag_reg    <= skid_tag_reg;
        out_err_reg    <= skid_err_reg;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        out_imm_reg <= new_imm;
        out_tag_reg <= i_tag;
        out_err_reg <= new_err;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_reg) begin
        out_valid_reg <= 1'b1;
        out_imm_reg   <= new_imm;
        out_tag_reg   <= i_tag;
        out_err_reg   <= new_err;
      end else begin
        skid_valid_reg <= 1'b1;
        skid_imm_reg   <= new_imm;
        skid_tag_reg   <= i_tag;
        skid_err_reg   <= new_err;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are both
// checked against a capacity-2 FIFO reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [24:0] in_instr;
  logic [2:0]  in_src;
  logic [31:0] in_tag;
  logic        out_rdy;

  logic        v32, r32, e32;
  logic [31:0] imm32, tag32;
  logic        v64, r64, e64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] tag;
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic        err;
  } entry_t;

  entry_t model_q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(r32),
    .i_instr(in_instr), .i_immsrc(in_src), .i_tag(in_tag), .o_valid(v32),
    .i_ready(out_rdy), .o_immext(imm32), .o_tag(tag32), .o_immsrc_err(e32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(r64),
    .i_instr(in_instr), .i_immsrc(in_src), .i_tag(in_tag), .o_valid(v64),
    .i_ready(out_rdy), .o_immext(imm64), .o_tag(tag64), .o_immsrc_err(e64)
  );

  // Immediate from the ISA field definitions, sign-extended to 64 bits; the 32-bit
  // result is its low half (SHAMT differs in field width between XLENs).
  function automatic logic [63:0] ref_imm(logic [31:0] ins, logic [2:0] src, int xlen);
    logic signed [63:0] v;
    case (src)
      3'd0: v = $signed(ins[31:20]);
      3'd1: v = $signed({ins[31:25], ins[11:7]});
      3'd2: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      3'd3: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      3'd4: v = $signed({ins[31:12], 12'h000});
      3'd5: v = (xlen == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
      3'd6: v = 64'(ins[19:15]);
      default: v = 64'd0;
    endcase
    return (xlen == 32) ? {32'd0, v[31:0]} : v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit exp_v;
    bit exp_r;
    exp_v = model_q.size() > 0;
    exp_r = model_q.size() < 2;
    chk("valid32", {63'd0, v32}, {63'd0, exp_v});
    chk("ready32", {63'd0, r32}, {63'd0, exp_r});
    chk("valid64", {63'd0, v64}, {63'd0, exp_v});
    chk("ready64", {63'd0, r64}, {63'd0, exp_r});
    if (exp_v) begin
      chk("imm32", {32'd0, imm32}, model_q[0].imm32);
      chk("tag32", {32'd0, tag32}, {32'd0, model_q[0].tag});
      chk("err32", {63'd0, e32}, {63'd0, model_q[0].err});
      chk("imm64", imm64, model_q[0].imm64);
      chk("tag64", {32'd0, tag64}, {32'd0, model_q[0].tag});
      chk("err64", {63'd0, e64}, {63'd0, model_q[0].err});
    end
  endtask

  task automatic check_reset_values(string where);
    chk({where, "_valid"}, {62'd0, v32, v64}, 64'd0);
    chk({where, "_ready"}, {62'd0, r32, r64}, 64'd3);
    chk({where, "_imm32"}, {32'd0, imm32}, 64'd0);
    chk({where, "_imm64"}, imm64, 64'd0);
    chk({where, "_tags"}, {tag32, tag64}, 64'd0);
    chk({where, "_err"}, {62'd0, e32, e64}, 64'd0);
  endtask

  // One clock cycle: drive at negedge, check state, advance model at posedge.
  task automatic step(bit v, logic [31:0] ins, logic [2:0] src, logic [31:0] tg,
                      bit rdy, bit fl);
    int   n;
    entry_t e;
    in_valid = v;
    in_instr = ins[31:7];
    in_src   = src;
    in_tag   = tg;
    out_rdy  = rdy;
    flush    = fl;
    check_outputs();
    @(posedge clk);
    n = model_q.size();
    if (fl) begin
      model_q.delete();
    end else begin
      if (n > 0 && rdy) void'(model_q.pop_front());
      if (v && n < 2) begin
        e.tag   = tg;
        e.imm32 = ref_imm(ins, src, 32);
        e.imm64 = ref_imm(ins, src, 64);
        e.err   = (src == 3'd7);
        model_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(bit rdy);
    step(1'b0, 32'd0, 3'd0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    in_src = '0; in_tag = '0; out_rdy = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);

    // Single transfers per format, each followed by a drain cycle.
    step(1'b1, 32'hFFF00093, 3'd0, 32'h100, 1'b1, 1'b0); idle(1'b1);
    step(1'b1, 32'hFE000EE3, 3'd2, 32'h101, 1'b1, 1'b0); idle(1'b1);
    step(1'b1, 32'h123452B7, 3'd4, 32'h102, 1'b1, 1'b0); idle(1'b1);
    step(1'b1, 32'h01F09093, 3'd5, 32'h103, 1'b1, 1'b0); idle(1'b1);
    step(1'b1, 32'h340FD073, 3'd6, 32'h104, 1'b1, 1'b0); idle(1'b1);
    step(1'b1, 32'h12345678, 3'd7, 32'h105, 1'b1, 1'b0); idle(1'b1);
    step(1'b1, 32'h800002B7, 3'd4, 32'h106, 1'b1, 1'b0); idle(1'b1);
    step(1'b1, 32'h03F09093, 3'd5, 32'h107, 1'b1, 1'b0); idle(1'b1);
    step(1'b1, 32'hFE112E23, 3'd1, 32'h108, 1'b1, 1'b0); idle(1'b1);
    step(1'b1, 32'hFF5FF0EF, 3'd3, 32'h109, 1'b1, 1'b0); idle(1'b1);

    // Backpressure: A, B fill both slots, C waits until the skid frees.
    step(1'b1, 32'hFFF00093, 3'd0, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'h00500093, 3'd0, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'h123452B7, 3'd4, 32'hC, 1'b0, 1'b0);
    step(1'b1, 32'h123452B7, 3'd4, 32'hC, 1'b0, 1'b0);
    step(1'b1, 32'h123452B7, 3'd4, 32'hC, 1'b1, 1'b0);
    step(1'b1, 32'h123452B7, 3'd4, 32'hC, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);

    // Streaming at full rate.
    for (int i = 0; i < 16; i++)
      step(1'b1, $urandom, 3'(i % 7), 32'(i), 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);

    // Flush with both slots full and a same-cycle input.
    step(1'b1, $urandom, 3'd0, 32'h51, 1'b0, 1'b0);
    step(1'b1, $urandom, 3'd1, 32'h52, 1'b0, 1'b0);
    step(1'b1, $urandom, 3'd2, 32'h53, 1'b1, 1'b1);
    idle(1'b1); idle(1'b1);

    // Asynchronous reset between edges with both slots full.
    step(1'b1, $urandom, 3'd0, 32'h61, 1'b0, 1'b0);
    step(1'b1, $urandom, 3'd3, 32'h62, 1'b0, 1'b0);
    in_valid = 1'b0;
    check_outputs();
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hFFF00093, 3'd0, 32'h71, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);

    // Randomised traffic with occasional stalls and flushes.
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, $urandom, 3'($urandom % 8), $urandom,
           ($urandom % 3) != 0, ($urandom % 25) == 0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
